// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared types and sizes for the 4:1 mux scan controller.
package mux4_scan_ctrl_pkg;
   localparam int SEL_W = 2;
   localparam int N_IN  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;
endpackage

// File: rtl/mux4_scan_ctrl_settle_timer.sv
// Load/decrement settle counter; done is high while the count is zero.
// Loading SETTLE_CYCLES-1 gives SETTLE_CYCLES clocks of settling before done.
module mux4_scan_ctrl_settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic done
);
   localparam int W = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [W-1:0] RELOAD = W'(SETTLE_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = RELOAD;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);
endmodule

// File: rtl/mux4_scan_ctrl.sv
// Steps the mux select through 0..3, samples Y after settling and presents a 4-bit word;
// valid rises 4*(SETTLE_CYCLES+1) edges after start and is held (no further sampling) until ready.
module mux4_scan_ctrl
   import mux4_scan_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CONT          = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       Y_in,
   output logic       A0,
   output logic       A1,
   output logic [3:0] word,
   output logic       valid,
   input  logic       ready,
   output logic       busy
);
   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [N_IN-2:0]    shadow_q, shadow_d;
   logic [N_IN-1:0]    word_q, word_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               tmr_load, tmr_dec, tmr_done;

   mux4_scan_ctrl_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .load(tmr_load),
      .dec (tmr_dec),
      .done(tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      word_d   = word_q;
      valid_d  = valid_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_SETTLE;
               sel_d    = '0;
               tmr_load = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (tmr_done) begin
               state_d = ST_SAMPLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_SAMPLE: begin
            sel_d = sel_q + 2'd1;
            // The last input goes straight into the word, skipping the shadow.
            case (sel_q)
               2'd0:    shadow_d[0] = Y_in;
               2'd1:    shadow_d[1] = Y_in;
               2'd2:    shadow_d[2] = Y_in;
               default: begin
                  word_d  = {Y_in, shadow_q};
                  valid_d = 1'b1;
               end
            endcase
            if (sel_q == 2'd3) begin
               state_d = ST_HOLD;
            end else begin
               state_d  = ST_SETTLE;
               tmr_load = 1'b1;
            end
         end
         ST_HOLD: begin
            if (valid_q && ready) begin
               valid_d = 1'b0;
               if (CONT != 0) begin
                  state_d  = ST_SETTLE;
                  tmr_load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         shadow_q <= '0;
         word_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         word_q   <= word_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign A0    = sel_q[0];
   assign A1    = sel_q[1];
   assign word  = word_q;
   assign valid = valid_q;
   assign busy  = busy_q;
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: three instances (default, continuous, one-cycle settle)
// checked every cycle against a timeline model plus directed literal expectations.
module tb_mux4_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] start, ready, a0, a1, vld, bsy;
   logic [3:0] d   [3];
   logic [3:0] wrd [3];

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mux4_scan_ctrl #(.SETTLE_CYCLES(2), .CONT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .Y_in(d[0][{a1[0], a0[0]}]),
      .A0(a0[0]), .A1(a1[0]), .word(wrd[0]), .valid(vld[0]), .ready(ready[0]), .busy(bsy[0]));
   mux4_scan_ctrl #(.SETTLE_CYCLES(2), .CONT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .Y_in(d[1][{a1[1], a0[1]}]),
      .A0(a0[1]), .A1(a1[1]), .word(wrd[1]), .valid(vld[1]), .ready(ready[1]), .busy(bsy[1]));
   mux4_scan_ctrl #(.SETTLE_CYCLES(1), .CONT(0)) dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .Y_in(d[2][{a1[2], a0[2]}]),
      .A0(a0[2]), .A1(a1[2]), .word(wrd[2]), .valid(vld[2]), .ready(ready[2]), .busy(bsy[2]));

   task automatic chk(input string nm, input int i, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s[inst%0d]: got %0h, expected %0h", nm, i, act, exp);
      end
   endtask

   // Model: each select occupies per[i] edges; bit k is captured on edge (k+1)*per[i]
   // after the start edge, and the word is presented once bit 3 is captured.
   int         per  [3] = '{3, 3, 2};
   bit         cont [3] = '{1'b0, 1'b1, 1'b0};
   int         m_t  [3] = '{-1, -1, -1};
   bit         m_hold [3];
   logic [3:0] m_acc  [3];
   logic [3:0] m_word [3];

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_t[i] = -1; m_hold[i] = 1'b0; m_acc[i] = '0; m_word[i] = '0;
         end else if (m_hold[i]) begin
            if (ready[i]) begin
               m_hold[i] = 1'b0;
               m_t[i]    = cont[i] ? 0 : -1;
            end
         end else if (m_t[i] >= 0) begin
            m_t[i]++;
            if (m_t[i] % per[i] == 0) begin
               int k;
               k = m_t[i] / per[i] - 1;
               m_acc[i][k] = d[i][k];
               if (k == 3) begin
                  m_word[i] = m_acc[i];
                  m_hold[i] = 1'b1;
                  m_t[i]    = -1;
               end
            end
         end else if (start[i]) begin
            m_t[i] = 0;
         end
      end
   end

   int rise_cnt [3] = '{0, 0, 0};
   int rise_cyc [3] = '{0, 0, 0};
   bit pv [3];

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            int es;
            es = m_hold[i] ? 0 : ((m_t[i] >= 0) ? m_t[i] / per[i] : 0);
            chk("valid", i, int'(vld[i]), int'(m_hold[i]));
            chk("word", i, int'(wrd[i]), int'(m_word[i]));
            chk("busy", i, int'(bsy[i]), int'(m_hold[i] || (m_t[i] >= 0)));
            chk("sel", i, int'({a1[i], a0[i]}), es);
            if (vld[i] && !pv[i]) begin
               rise_cnt[i]++;
               rise_cyc[i] = cyc;
            end
            pv[i] = vld[i];
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(input int i, output int t0);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_rise(input int i, input int n0, output int tr);
      int k = 0;
      while (rise_cnt[i] == n0 && k < 60) begin
         tick();
         k++;
      end
      if (rise_cnt[i] == n0) chk("valid_timeout", i, 0, 1);
      tr = rise_cyc[i];
   endtask

   task automatic chk_idle_lit(input string nm, input int i);
      chk({nm, "_valid"}, i, int'(vld[i]), 0);
      chk({nm, "_busy"}, i, int'(bsy[i]), 0);
      chk({nm, "_sel"}, i, int'({a1[i], a0[i]}), 0);
   endtask

   initial begin
      int t0, t1, t2, tr, n;
      start = '0; ready = '0;
      for (int i = 0; i < 3; i++) d[i] = '0;
      #1 rst = 1'b1;
      #2;
      for (int i = 0; i < 3; i++) begin
         chk_idle_lit("reset", i);
         chk("reset_word", i, int'(wrd[i]), 0);
      end
      tick(); tick();
      rst = 1'b0;

      // single scan
      d[0] = 4'b1011; ready[0] = 1'b1; n = rise_cnt[0];
      pulse_start(0, t0);
      wait_rise(0, n, tr);
      chk("single_latency", 0, tr - t0, 12);
      chk("single_word", 0, int'(wrd[0]), 4'b1011);
      tick();
      chk_idle_lit("single_done", 0);

      // ready without valid
      repeat (5) tick();
      chk_idle_lit("ready_no_valid", 0);

      // back-pressure
      ready[0] = 1'b0; d[0] = 4'b0110; n = rise_cnt[0];
      pulse_start(0, t0);
      wait_rise(0, n, tr);
      repeat (20) tick();
      chk("bp_valid", 0, int'(vld[0]), 1);
      chk("bp_word", 0, int'(wrd[0]), 4'b0110);
      chk("bp_sel", 0, int'({a1[0], a0[0]}), 0);
      chk("bp_rises", 0, rise_cnt[0] - n, 1);
      ready[0] = 1'b1;
      tick();
      chk_idle_lit("bp_release", 0);

      // start ignored while busy, Y glitch during settle
      d[0] = 4'b0101; n = rise_cnt[0];
      pulse_start(0, t0);
      for (int r = 1; r <= 40; r++) begin
         tick();
         start[0] = (r == 3 || r == 7);
         if (r == 4) d[0] = 4'hF;
         if (r == 5) d[0] = 4'b0101;
      end
      start[0] = 1'b0;
      chk("ign_rises", 0, rise_cnt[0] - n, 1);
      chk("ign_latency", 0, rise_cyc[0] - t0, 12);
      chk("ign_word", 0, int'(wrd[0]), 4'b0101);

      // asynchronous reset mid-SETTLE with sel=2
      d[0] = 4'b1001;
      pulse_start(0, t0);
      repeat (7) tick();
      chk("pre_rst_sel", 0, int'({a1[0], a0[0]}), 2);
      chk("pre_rst_busy", 0, int'(bsy[0]), 1);
      #2 rst = 1'b1;
      #1;
      chk_idle_lit("async_rst", 0);
      chk("async_rst_word", 0, int'(wrd[0]), 0);
      tick();
      rst = 1'b0;

      // SETTLE_CYCLES=1
      d[2] = 4'b1000; ready[2] = 1'b1; n = rise_cnt[2];
      pulse_start(2, t0);
      wait_rise(2, n, tr);
      chk("sc1_latency", 2, tr - t0, 8);
      chk("sc1_word", 2, int'(wrd[2]), 4'b1000);

      // continuous mode
      d[1] = 4'h5; ready[1] = 1'b1; n = rise_cnt[1];
      pulse_start(1, t0);
      wait_rise(1, n, t1);
      chk("cont_latency", 1, t1 - t0, 12);
      chk("cont_word0", 1, int'(wrd[1]), 4'h5);
      d[1] = 4'hA;
      wait_rise(1, n + 1, t2);
      chk("cont_period", 1, t2 - t1, 13);
      chk("cont_word1", 1, int'(wrd[1]), 4'hA);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
